// File: rtl/qarma_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// qarma_wb_sequencer_if
//   Wishbone classic-cycle bus between the QARMA job sequencer (initiator)
//   and the QARMA control register block (target).
//
//   wbm_cyc_o / wbm_stb_o : bus cycle / strobe, always driven equal
//   wbm_we_o              : write enable
//   wbm_sel_o             : byte selects, 4'hF while strobing
//   wbm_adr_o             : byte address
//   wbm_dat_o             : write data (0 on reads)
//   wbm_ack_i             : target acknowledge
//   wbm_dat_i             : read data, valid with ack
// ---------------------------------------------------------------------------
interface qarma_wb_sequencer_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/qarma_wb_sequencer.sv
// ---------------------------------------------------------------------------
// qarma_wb_sequencer
//   Runs one QARMA-64 encryption job over Wishbone: holds the core in reset,
//   loads key/plaintext/tweak, releases the core, polls status until ready,
//   then reads the 64-bit ciphertext back.
//
// Parameters
//   BASE_ADDR   : base address of the QARMA control block
//   POLL_LIMIT  : maximum status reads per job (>=1)
//   ACK_TIMEOUT : maximum edges a strobe is held without ack (>=2)
//
// Ports
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   start_i             : job request, honoured only when idle
//   key_i/tweak_i/data_i: job operands, latched when a start is accepted
//   busy_o              : job in progress
//   done_o / err_o      : one-cycle completion / abort pulses
//   err_code_o          : 01 ack timeout, 10 poll limit; held until next start
//   result_o            : ciphertext of the last successful job
//   wbm                 : Wishbone initiator bus
// ---------------------------------------------------------------------------
module qarma_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned POLL_LIMIT  = 1024,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        start_i,
    input  logic [127:0]                key_i,
    input  logic [63:0]                 tweak_i,
    input  logic [63:0]                 data_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [1:0]                  err_code_o,
    output logic [63:0]                 result_o,
    qarma_wb_sequencer_if.master        wbm
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [PW-1:0] PCNT_MAX = PW'(POLL_LIMIT - 1);
    localparam logic [TW-1:0] TCNT_MAX = TW'(ACK_TIMEOUT - 1);

    // Step indices with special handling; all others are plain writes.
    localparam logic [3:0] STEP_POLL = 4'd10;
    localparam logic [3:0] STEP_LO   = 4'd11;
    localparam logic [3:0] STEP_HI   = 4'd12;

    localparam logic [1:0] ERR_ACK  = 2'b01;
    localparam logic [1:0] ERR_POLL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      step_q, step_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [31:0]     lo_q, lo_d;
    logic [63:0]     result_q, result_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            accept;

    logic [127:0]    key_q;
    logic [63:0]     tweak_q;
    logic [63:0]     data_q;

    // Access decode for the current step
    logic [7:0]      acc_off;
    logic            acc_we;
    logic [31:0]     acc_wdat;
    logic            stb;

    always_comb begin
        acc_off  = 8'h00;
        acc_we   = 1'b0;
        acc_wdat = 32'h0;
        case (step_q)
            4'd0:  begin acc_off = 8'h04; acc_we = 1'b1; acc_wdat = 32'h0;          end
            4'd1:  begin acc_off = 8'h10; acc_we = 1'b1; acc_wdat = key_q[31:0];    end
            4'd2:  begin acc_off = 8'h14; acc_we = 1'b1; acc_wdat = key_q[63:32];   end
            4'd3:  begin acc_off = 8'h18; acc_we = 1'b1; acc_wdat = key_q[95:64];   end
            4'd4:  begin acc_off = 8'h1C; acc_we = 1'b1; acc_wdat = key_q[127:96];  end
            4'd5:  begin acc_off = 8'h20; acc_we = 1'b1; acc_wdat = data_q[31:0];   end
            4'd6:  begin acc_off = 8'h24; acc_we = 1'b1; acc_wdat = data_q[63:32];  end
            4'd7:  begin acc_off = 8'h40; acc_we = 1'b1; acc_wdat = tweak_q[31:0];  end
            4'd8:  begin acc_off = 8'h44; acc_we = 1'b1; acc_wdat = tweak_q[63:32]; end
            4'd9:  begin acc_off = 8'h08; acc_we = 1'b1; acc_wdat = 32'h0;          end
            4'd10: acc_off = 8'h00;
            4'd11: acc_off = 8'h30;
            4'd12: acc_off = 8'h34;
            default: acc_off = 8'h00;
        endcase
    end

    // Strobe is exactly the ACCESS state; ack is only acted on there, so
    // acks arriving in GAP/IDLE are ignored by construction.
    assign stb           = (state_q == S_ACCESS);
    assign wbm.wbm_cyc_o = stb;
    assign wbm.wbm_stb_o = stb;
    assign wbm.wbm_we_o  = stb & acc_we;
    assign wbm.wbm_sel_o = stb ? 4'hF : 4'h0;
    assign wbm.wbm_adr_o = stb ? (BASE_ADDR + {24'h0, acc_off}) : 32'h0;
    assign wbm.wbm_dat_o = (stb && acc_we) ? acc_wdat : 32'h0;

    assign busy_o     = (state_q == S_ACCESS) || (state_q == S_GAP);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERR);
    assign err_code_o = err_code_q;
    assign result_o   = result_q;

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tcnt_d     = tcnt_q;
        pcnt_d     = pcnt_q;
        lo_d       = lo_q;
        result_d   = result_q;
        err_code_d = err_code_q;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_d    = S_ACCESS;
                    step_d     = 4'd0;
                    tcnt_d     = '0;
                    pcnt_d     = '0;
                    err_code_d = 2'b00;
                end
            end
            S_ACCESS: begin
                if (wbm.wbm_ack_i) begin
                    tcnt_d  = '0;
                    state_d = S_GAP;
                    case (step_q)
                        STEP_POLL: begin
                            if (wbm.wbm_dat_i[0]) begin
                                step_d = STEP_LO;
                            end else if (pcnt_q == PCNT_MAX) begin
                                state_d    = S_ERR;
                                err_code_d = ERR_POLL;
                            end else begin
                                // stay on the poll step, re-read after GAP
                                pcnt_d = pcnt_q + 1'b1;
                            end
                        end
                        STEP_LO: begin
                            lo_d   = wbm.wbm_dat_i;
                            step_d = STEP_HI;
                        end
                        STEP_HI: begin
                            // both halves land in result together
                            result_d = {wbm.wbm_dat_i, lo_q};
                            state_d  = S_DONE;
                        end
                        default: step_d = step_q + 4'd1;
                    endcase
                end else if (tcnt_q == TCNT_MAX) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_ACK;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_ACCESS;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            step_q     <= 4'd0;
            tcnt_q     <= '0;
            pcnt_q     <= '0;
            lo_q       <= 32'h0;
            result_q   <= 64'h0;
            err_code_q <= 2'b00;
            key_q      <= 128'h0;
            tweak_q    <= 64'h0;
            data_q     <= 64'h0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tcnt_q     <= tcnt_d;
            pcnt_q     <= pcnt_d;
            lo_q       <= lo_d;
            result_q   <= result_d;
            err_code_q <= err_code_d;
            if (accept) begin
                key_q   <= key_i;
                tweak_q <= tweak_i;
                data_q  <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_qarma_wb_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qarma_wb_sequencer
//   Two sequencers: dut0 (default limits) with a configurable responder for
//   wait states, poll counts and stray acks; dut1 (POLL_LIMIT=4) with a
//   zero-wait responder whose ready bit is a plain level. Expected bus
//   accesses and job outcomes are queued when a job starts; a monitor on the
//   falling edge pops and compares them as the DUTs present acks/pulses.
// ---------------------------------------------------------------------------
module tb_qarma_wb_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          TO   = 16;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } acc_t;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [63:0] res;
        int          cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    acc_t acc_q0[$], acc_q1[$];
    res_t res_q0[$], res_q1[$];

    logic         start0 = 1'b0, start1 = 1'b0;
    logic [127:0] key   = '0;
    logic [63:0]  tweak = '0, data = '0;
    logic         busy0, done0, err0, busy1, done1, err1;
    logic [1:0]   code0, code1;
    logic [63:0]  res0, res1;

    qarma_wb_sequencer_if bus0 ();
    qarma_wb_sequencer_if bus1 ();

    qarma_wb_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(1024), .ACK_TIMEOUT(TO)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start0),
        .key_i(key), .tweak_i(tweak), .data_i(data),
        .busy_o(busy0), .done_o(done0), .err_o(err0), .err_code_o(code0),
        .result_o(res0), .wbm(bus0.master)
    );

    qarma_wb_sequencer #(.BASE_ADDR(BASE), .POLL_LIMIT(4), .ACK_TIMEOUT(TO)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start1),
        .key_i(key), .tweak_i(tweak), .data_i(data),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .err_code_o(code1),
        .result_o(res1), .wbm(bus1.master)
    );

    // ---------------- responder for dut0 ----------------
    logic        ack0_r;
    logic        stray0 = 1'b0;
    int          wcnt0, polls0;
    logic [31:0] wait_adr = 32'hFFFF_FFFF;
    int          wait_n = 0;
    int          poll_rdy_at = 1;
    logic [31:0] out_lo = '0, out_hi = '0;
    logic [31:0] dat0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_r <= 1'b0;
            wcnt0  <= 0;
            polls0 <= 0;
        end else begin
            if (start0 && !busy0) polls0 <= 0;
            if (ack0_r) begin
                ack0_r <= 1'b0;
                if (bus0.wbm_adr_o == BASE && !bus0.wbm_we_o) polls0 <= polls0 + 1;
            end else if (bus0.wbm_stb_o) begin
                if (wcnt0 >= ((bus0.wbm_adr_o == wait_adr) ? wait_n : 0)) begin
                    ack0_r <= 1'b1;
                    wcnt0  <= 0;
                end else begin
                    wcnt0 <= wcnt0 + 1;
                end
            end else begin
                wcnt0 <= 0;
            end
        end
    end

    always_comb begin
        dat0 = 32'h0;
        if (bus0.wbm_adr_o == BASE)
            dat0 = {31'h0, (poll_rdy_at != 0) && (polls0 + 1 >= poll_rdy_at)};
        else if (bus0.wbm_adr_o == BASE + 32'h30)
            dat0 = out_lo;
        else if (bus0.wbm_adr_o == BASE + 32'h34)
            dat0 = out_hi;
    end
    assign bus0.wbm_dat_i = dat0;
    assign bus0.wbm_ack_i = ack0_r | stray0;

    // ---------------- responder for dut1 ----------------
    logic        ack1_r;
    logic        rdy1 = 1'b1;
    logic [31:0] dat1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack1_r <= 1'b0;
        else        ack1_r <= bus1.wbm_stb_o && !ack1_r;
    end

    always_comb begin
        dat1 = 32'h0;
        if (bus1.wbm_adr_o == BASE)                dat1 = {31'h0, rdy1};
        else if (bus1.wbm_adr_o == BASE + 32'h30)  dat1 = 32'h1111_2222;
        else if (bus1.wbm_adr_o == BASE + 32'h34)  dat1 = 32'h3333_4444;
    end
    assign bus1.wbm_dat_i = dat1;
    assign bus1.wbm_ack_i = ack1_r;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    logic        p_stb[2];
    logic        p_we[2];
    logic [31:0] p_adr[2], p_dat[2];

    task automatic mon(input int w, input logic cyc, stb, we, ack, input logic [3:0] sel,
                       input logic [31:0] adr, dat, input logic busy, done, err,
                       input logic [1:0] code, input logic [63:0] res);
        acc_t e;
        res_t r;
        int   qs;
        if (stb && ack) begin
            qs = (w == 1) ? acc_q1.size() : acc_q0.size();
            if (qs == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bus%0d_unexpected_access: adr %h we %b, expected no access", w, adr, we);
            end else begin
                if (w == 1) e = acc_q1.pop_front();
                else        e = acc_q0.pop_front();
                chk($sformatf("bus%0d_adr", w), {32'h0, adr}, {32'h0, e.adr});
                chk($sformatf("bus%0d_we_dat@%h", w, e.adr), {31'h0, we, dat}, {31'h0, e.we, e.dat});
                chk($sformatf("bus%0d_cyc_sel", w), {59'h0, cyc, sel}, {59'h0, 1'b1, 4'hF});
            end
        end
        if (p_stb[w] && stb) begin
            chk($sformatf("bus%0d_adr_hold", w), {32'h0, adr}, {32'h0, p_adr[w]});
            chk($sformatf("bus%0d_we_dat_hold", w), {31'h0, we, dat}, {31'h0, p_we[w], p_dat[w]});
        end
        p_stb[w] = stb;
        p_adr[w] = adr;
        p_we[w]  = we;
        p_dat[w] = dat;
        if (done || err) begin
            qs = (w == 1) ? res_q1.size() : res_q0.size();
            if (qs == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL job%0d_unexpected_pulse: done %b err %b, expected none", w, done, err);
            end else begin
                if (w == 1) r = res_q1.pop_front();
                else        r = res_q0.pop_front();
                chk($sformatf("job%0d_done_err", w), {62'h0, done, err}, r.is_err ? 64'h1 : 64'h2);
                chk($sformatf("job%0d_err_code", w), {62'h0, code}, {62'h0, r.code});
                chk($sformatf("job%0d_result", w), res, r.res);
                chk($sformatf("job%0d_cycle", w), 64'(cyc_cnt), 64'(r.cyc));
                chk($sformatf("job%0d_busy_cyc_low", w), {62'h0, busy, cyc}, 64'h0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            p_stb[0] = 1'b0;
            p_stb[1] = 1'b0;
        end else begin
            mon(0, bus0.wbm_cyc_o, bus0.wbm_stb_o, bus0.wbm_we_o, bus0.wbm_ack_i, bus0.wbm_sel_o,
                bus0.wbm_adr_o, bus0.wbm_dat_o, busy0, done0, err0, code0, res0);
            mon(1, bus1.wbm_cyc_o, bus1.wbm_stb_o, bus1.wbm_we_o, bus1.wbm_ack_i, bus1.wbm_sel_o,
                bus1.wbm_adr_o, bus1.wbm_dat_o, busy1, done1, err1, code1, res1);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic void push_acc(input int w, input logic [31:0] off, input logic we, input logic [31:0] d);
        acc_t e;
        e.adr = BASE + off;
        e.we  = we;
        e.dat = d;
        if (w == 1) acc_q1.push_back(e);
        else        acc_q0.push_back(e);
    endfunction

    // Expected access list: the first n_w writes, n_polls status reads,
    // then (optionally) the two ciphertext reads.
    function automatic void push_seq(input int w, input logic [127:0] k, input logic [63:0] t, d,
                                     input int n_w, n_polls, input bit rd);
        logic [31:0] offs [10];
        logic [31:0] dats [10];
        offs = '{32'h04, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h40, 32'h44, 32'h08};
        dats = '{32'h0, k[31:0], k[63:32], k[95:64], k[127:96], d[31:0], d[63:32], t[31:0], t[63:32], 32'h0};
        for (int i = 0; i < n_w; i++) push_acc(w, offs[i], 1'b1, dats[i]);
        for (int i = 0; i < n_polls; i++) push_acc(w, 32'h00, 1'b0, 32'h0);
        if (rd) begin
            push_acc(w, 32'h30, 1'b0, 32'h0);
            push_acc(w, 32'h34, 1'b0, 32'h0);
        end
    endfunction

    // Issues a start and queues the expected bus trace and outcome; lat is
    // the outcome edge relative to the start edge S. Returns at the
    // falling edge right after S.
    task automatic run(input int w, input logic [127:0] k, input logic [63:0] t, d,
                       input int n_w, n_polls, input bit rd, input bit is_err,
                       input logic [1:0] code, input logic [63:0] res, input int lat);
        res_t r;
        @(negedge clk);
        key   = k;
        tweak = t;
        data  = d;
        if (w == 1) start1 = 1'b1;
        else        start0 = 1'b1;
        push_seq(w, k, t, d, n_w, n_polls, rd);
        r.is_err = is_err;
        r.code   = code;
        r.res    = res;
        r.cyc    = cyc_cnt + 1 + lat;
        if (w == 1) res_q1.push_back(r);
        else        res_q0.push_back(r);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (w == 1) chk("start1_busy_stb", {62'h0, busy1, bus1.wbm_stb_o}, 64'h3);
        else        chk("start0_busy_stb", {62'h0, busy0, bus0.wbm_stb_o}, 64'h3);
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while ((acc_q0.size() + acc_q1.size() + res_q0.size() + res_q1.size()) != 0 && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (i >= lim) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries outstanding, expected 0",
                     acc_q0.size() + acc_q1.size() + res_q0.size() + res_q1.size());
            acc_q0.delete(); acc_q1.delete(); res_q0.delete(); res_q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    localparam logic [127:0] K0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [63:0]  T0 = 64'h0F0E0D0C_0B0A0908;
    localparam logic [63:0]  D0 = 64'hDEADBEEF_CAFEF00D;

    initial begin
        int act;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_status", {57'h0, busy0, done0, err0, code0, busy1, err1}, 64'h0);
        chk("rst_result", res0, 64'h0);
        chk("rst_bus", {25'h0, bus0.wbm_cyc_o, bus0.wbm_stb_o, bus0.wbm_we_o, bus0.wbm_sel_o, bus0.wbm_adr_o}, 64'h0);
        chk("rst_wdat", {32'h0, bus0.wbm_dat_o}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a strobe: abort, no pulse, bus quiet afterwards
        out_lo = 32'h89AB_CDEF;
        out_hi = 32'h0123_4567;
        run(0, K0, T0, D0, 10, 1, 1'b1, 1'b0, 2'b00, 64'h0123_4567_89AB_CDEF, 38);
        repeat (6) @(negedge clk);
        chk("pre_reset_stb_0x14", {31'h0, bus0.wbm_stb_o, bus0.wbm_adr_o}, {31'h0, 1'b1, BASE + 32'h14});
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_bus", {25'h0, bus0.wbm_cyc_o, bus0.wbm_stb_o, bus0.wbm_we_o, bus0.wbm_sel_o, bus0.wbm_adr_o}, 64'h0);
        chk("async_rst_status", {59'h0, busy0, done0, err0, code0}, 64'h0);
        chk("async_rst_wdat", {32'h0, bus0.wbm_dat_o}, 64'h0);
        acc_q0.delete();
        res_q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            act = act | int'(bus0.wbm_cyc_o) | int'(busy0) | int'(done0) | int'(err0);
        end
        chk("post_reset_idle", 64'(act), 64'h0);

        // nominal job, ready on first poll: final ack S+38
        run(0, K0, T0, D0, 10, 1, 1'b1, 1'b0, 2'b00, 64'h0123_4567_89AB_CDEF, 38);
        drain(200);

        // ready on 5th status read: 17 accesses, final ack S+50
        poll_rdy_at = 5;
        out_lo = 32'h7654_3210;
        out_hi = 32'hFEDC_BA98;
        run(0, 128'hA5A5A5A5_5A5A5A5A_01010101_F0F0F0F0, 64'h1, 64'h8000_0000_0000_0001,
            10, 5, 1'b1, 1'b0, 2'b00, 64'hFEDC_BA98_7654_3210, 50);
        drain(200);

        // 3 wait states on the 0x18 write: completes 3 cycles later
        poll_rdy_at = 1;
        wait_adr = BASE + 32'h18;
        wait_n   = 3;
        out_lo = 32'h4455_6677;
        out_hi = 32'h0011_2233;
        run(0, K0, T0, D0, 10, 1, 1'b1, 1'b0, 2'b00, 64'h0011_2233_4455_6677, 41);
        drain(200);

        // no ack within ACK_TIMEOUT on 0x18: abort code 01, result kept
        wait_n = TO;
        run(0, K0, T0, D0, 3, 0, 1'b0, 1'b1, 2'b01, 64'h0011_2233_4455_6677, 9 + TO);
        drain(200);
        chk("err_code_held", {62'h0, code0}, 64'h1);
        wait_adr = 32'hFFFF_FFFF;
        wait_n   = 0;

        // stray start and stray ack in a GAP, operands changing mid-job
        out_lo = 32'h0123_4567;
        out_hi = 32'h89AB_CDEF;
        run(0, 128'hFFEEDDCC_BBAA9988_77665544_33221100, 64'h0808_0909_0A0A_0B0B, 64'h1234_5678_9ABC_DEF0,
            10, 1, 1'b1, 1'b0, 2'b00, 64'h89AB_CDEF_0123_4567, 38);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        key    = ~key;
        data   = 64'h0;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        stray0 = 1'b1;
        @(negedge clk);
        stray0 = 1'b0;
        drain(200);

        // dut1: successful job, then never-ready hits the 4-read poll limit
        rdy1 = 1'b1;
        run(1, K0, T0, D0, 10, 1, 1'b1, 1'b0, 2'b00, 64'h3333_4444_1111_2222, 38);
        drain(200);
        rdy1 = 1'b0;
        run(1, K0, T0, D0, 10, 4, 1'b0, 1'b1, 2'b10, 64'h3333_4444_1111_2222, 41);
        drain(200);
        chk("poll_limit_result_kept", res1, 64'h3333_4444_1111_2222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qarma_wb_sequencer.md
# qarma_wb_sequencer

Wishbone classic-cycle initiator that runs one complete QARMA-64 encryption job against the QARMA control register block. On a start pulse it loads key, tweak and plaintext, releases the core from reset, polls the status register until ready, then reads back the ciphertext. It sits between a local job source (test controller or a firmware-less datapath) and the Wishbone bus that reaches the QARMA control block.

## Interface
- BASE_ADDR, 32'h3000_0000, base address of the QARMA control block
- POLL_LIMIT, 1024, maximum status reads per job (≥1)
- ACK_TIMEOUT, 16, maximum cycles a strobe is held without ack (≥2)

- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  job request, sampled only in IDLE
- key_i  in  128  key, latched on accepted start
- tweak_i  in  64  tweak, latched on accepted start
- data_i  in  64  plaintext, latched on accepted start
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse, job succeeded
- err_o  out  1  one-cycle pulse, job aborted
- err_code_o  out  2  01 ack timeout, 10 poll limit; held until next accepted start
- result_o  out  64  ciphertext of last successful job
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle / strobe (always equal)
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  constant 4'hF while strobing, else 0
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_ack_i  in  1  acknowledge
- wbm_dat_i  in  32  read data, valid with ack

## Operation
- States: IDLE, ACCESS (stb high), GAP (one idle cycle), DONE, ERR; step index selects the access.
- Step list (offsets from BASE_ADDR, W=write, R=read): W 0x04 data 0 (core reset); W 0x10/0x14/0x18/0x1C key[31:0]..key[127:96]; W 0x20/0x24 data[31:0], data[63:32]; W 0x40/0x44 tweak[31:0], tweak[63:32]; W 0x08 data 0 (release); R 0x00 poll; R 0x30 out[31:0]; R 0x34 out[63:32].
- Poll: ack with wbm_dat_i[0]=1 → advance to result reads; bit0=0 → GAP then re-read 0x00. POLL_LIMIT-th read still 0 → ERR code 10, no result reads.
- Ack accepted only at an edge where wbm_stb_o is high; acks while stb low are ignored.
- Reads: wbm_dat_o=0, we=0. Read data captured at the ack edge; result_o updated only when the 0x34 read acks (both halves written together).
- Ack timeout: stb held at most ACK_TIMEOUT edges; no ack by the last → drop cyc/stb, ERR code 01.
- DONE/ERR last one cycle, return to IDLE. start_i while busy ignored; inputs changing while busy have no effect.

## Timing
- Reset (async): cyc/stb/we=0, sel=0, adr=0, dat=0, busy=0, done=0, err=0, err_code=0, result=0, state IDLE. Reset mid-job aborts immediately, no pulse.
- Start accepted at edge S: busy_o and first stb high after S.
- Each access: stb rises after edge A, held until ack edge K, low for exactly one cycle (GAP), next stb rises after K+1. Zero-wait responder (ack on 2nd edge): 3 cycles per access.
- adr/we/dat stable for the whole strobe.
- N accesses with zero-wait responder: final ack at S+3N−1; done_o and updated result_o in the cycle after; busy_o low same cycle as done_o. Ready on first poll: N=13, final ack S+38.
- err_o asserted the cycle after the failing edge; busy_o low same cycle.

## Test plan
- Reset: hold wb_rst_ni low mid-strobe → all outputs at reset values asynchronously, no further bus activity after release until start.
- Nominal: key=0x00112233_44556677_8899AABB_CCDDEEFF, tweak=0x0F0E0D0C_0B0A0908, data=0xDEADBEEF_CAFEF00D, responder ready on 1st poll, out=0x01234567_89ABCDEF → exact 13-access address/data sequence, done_o after S+38, result_o=0x0123456789ABCDEF.
- Poll: ready on 5th status read → five reads of 0x00, final ack at S+50, done_o next cycle.
- Wait states: ack delayed 3 extra cycles on write 0x18 → stb, adr, dat held, job completes 3 cycles later; delay ACK_TIMEOUT cycles → err_o, err_code_o=01, cyc dropped.
- Poll limit: POLL_LIMIT=4, never ready → exactly 4 status reads, err_code_o=10, no 0x30/0x34 reads, result_o unchanged.
- Stray events: start_i pulsed while busy and ack driven during GAP → no new job, no step skipped.
